my_adder_4bit: RTL and testbench

//   Registered ripple-carry adder: sum_o <= a_i + b_i + carry_i, modulo 2**WIDTH.

---
 rtl/my_adder_pkg.sv | 14 +
 rtl/my_full_adder.sv | 24 ++
 rtl/my_adder_4bit.sv | 77 +++++++
 tb/tb_my_adder_4bit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/my_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_adder_pkg                                                    |
// | Brief    : Shared width default and word type for the registered adder.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package my_adder_pkg;

    localparam int unsigned MY_ADDER_WIDTH_DEFAULT = 4;

    typedef logic [MY_ADDER_WIDTH_DEFAULT-1:0] my_adder_word_t;

endpackage : my_adder_pkg
`default_nettype wire

// File: rtl/my_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_full_adder                                                   |
// | Brief    : One-bit combinational full adder, the ripple-chain cell.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module my_full_adder
    import my_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);

    logic w_half;

    assign w_half  = a_i ^ b_i;
    assign sum_o   = w_half ^ carry_i;
    assign carry_o = (a_i & b_i) | (carry_i & w_half);

endmodule : my_full_adder
`default_nettype wire

// File: rtl/my_adder_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_adder_4bit                                                   |
// | Brief    : Registered ripple-carry adder, sum = (a + b + cin) mod 2**WIDTH.|
// |            Define MY_ADDER_CARRY_OUT_EN to expose the registered carry_o.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module my_adder_4bit
    import my_adder_pkg::*;
#(
    parameter int unsigned WIDTH = MY_ADDER_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o
`ifdef MY_ADDER_CARRY_OUT_EN
    ,
    output logic             carry_o
`endif
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("my_adder_4bit: WIDTH must be within 1..32");
    end

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;

    assign w_carry[0] = carry_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        my_full_adder u_fa (
            .a_i     (a_i[i]),
            .b_i     (b_i[i]),
            .carry_i (w_carry[i]),
            .sum_o   (w_sum[i]),
            .carry_o (w_carry[i+1])
        );
    end

`ifdef MY_ADDER_CARRY_OUT_EN
    logic r_carry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry[WIDTH];
        end
    end

    assign carry_o = r_carry;
`else
    // Without the carry port the top carry is intentionally dropped.
    logic w_unused_carry;
    assign w_unused_carry = w_carry[WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end
`endif

    assign sum_o = r_sum;

endmodule : my_adder_4bit
`default_nettype wire

// File: tb/tb_my_adder_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_my_adder_4bit                                                |
// | Brief    : Scoreboard bench for my_adder_4bit (honours MY_ADDER_CARRY_OUT_EN).|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_my_adder_4bit;

    localparam int WIDTH = 4;

    typedef struct {
        int    sum;
        int    carry;
        string tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum;
`ifdef MY_ADDER_CARRY_OUT_EN
    logic             cout;
`endif

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   prev_sum = 0;
    bit   prev_valid = 1'b0;

    my_adder_4bit #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .a_i     (a),
        .b_i     (b),
        .carry_i (cin),
        .sum_o   (sum)
`ifdef MY_ADDER_CARRY_OUT_EN
        ,
        .carry_o (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_sum(input string tag, input logic [WIDTH-1:0] obs, input int expv);
        logic [WIDTH-1:0] e;
        e = expv[WIDTH-1:0];
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: sum observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic check_carry(input string tag, input logic obs, input int expv);
        logic e;
        e = expv[0];
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: carry observed=%0b expected=%0b", tag, obs, e);
        end
    endtask

    // Independent integer model: full result, then split into word and carry.
    task automatic push_expected(input int av, input int bv, input int cv, input string tag);
        exp_t e;
        int   full;
        full    = av + bv + cv;
        e.sum   = full % (1 << WIDTH);
        e.carry = (full >= (1 << WIDTH)) ? 1 : 0;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=0 entries expected=1");
        end else begin
            e = exp_q.pop_front();
            check_sum(e.tag, sum, e.sum);
`ifdef MY_ADDER_CARRY_OUT_EN
            check_carry({e.tag, "_carry"}, cout, e.carry);
`endif
            prev_sum   = e.sum;
            prev_valid = 1'b1;
        end
    endtask

    // Drive, confirm the output still holds the previous result, then one edge.
    task automatic step(input int av, input int bv, input int cv, input string tag);
        a   = av[WIDTH-1:0];
        b   = bv[WIDTH-1:0];
        cin = cv[0];
        push_expected(av, bv, cv, tag);
        #2;
        if (prev_valid) check_sum({tag, "_hold"}, sum, prev_sum);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    initial begin
        a = 4'd9; b = 4'd9; cin = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_sum("reset_async", sum, 0);
`ifdef MY_ADDER_CARRY_OUT_EN
        check_carry("reset_async_carry", cout, 0);
`endif
        @(posedge clk);
        #1;
        check_sum("reset_held_edge", sum, 0);
        #2 rst_n = 1'b1;
        #1;
        check_sum("reset_released_no_edge", sum, 0);

        step(9, 9, 1, "first_capture");

        step(0, 0, 0, "add_0_0_0");
        step(1, 0, 0, "add_1_0_0");
        step(7, 0, 0, "add_7_0_0");
        step(0, 7, 0, "add_0_7_0");
        step(5, 5, 0, "add_5_5_0");

        step(7, 0, 1, "cin_7_0_1");
        step(7, 7, 0, "cin_7_7_0");
        step(7, 7, 1, "cin_7_7_1");

        step(14, 5, 0, "wrap_14_5_0");
        step(15, 15, 1, "wrap_15_15_1");
        step(15, 0, 1, "wrap_15_0_1");
        step(0, 0, 1, "cin_only");

        for (int i = 0; i < 8; i++) begin
            step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), "latency_rand");
        end

        step(7, 7, 0, "pre_reset_14");
        a = 4'd1; b = 4'd2; cin = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_sum("midrun_reset_async", sum, 0);
`ifdef MY_ADDER_CARRY_OUT_EN
        check_carry("midrun_reset_carry", cout, 0);
`endif
        @(posedge clk);
        #1;
        check_sum("midrun_reset_held_edge", sum, 0);
        #2 rst_n = 1'b1;
        #1;
        check_sum("midrun_release_no_edge", sum, 0);
        prev_sum = 0;
        prev_valid = 1'b1;
        step(1, 2, 0, "post_reset_1_2_0");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d entries expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_my_adder_4bit
`default_nettype wire
